// File: rtl/vga_loader_pkg.sv
// Shared types and constants for the sprite RAM loader.
package vga_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VB,
    FETCH,
    WRITE,
    CTRL,
    DONE
  } state_e;

  localparam logic [13:0] CTRL_REG_ADDR = 14'h2003;
  localparam int          PIX_PER_WORD  = 16;
  localparam int          PIX_BITS      = 2;

endpackage

// File: rtl/vga_sprite_loader.sv
// Sprite RAM loader: pulls 32-bit words from a valid/ready source, unpacks
// 2-bit pixels into consecutive slot writes, optionally waits for vertical
// blanking first and optionally finishes with a sprite control write.
module vga_sprite_loader
  import vga_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int V_ACTIVE   = 480
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   pix_count,
  input  logic                  vsync_wait,
  input  logic                  ctrl_en,
  input  logic [4:0]            ctrl_val,
  input  logic [10:0]           y,
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  cs,
  output logic                  write,
  output logic [13:0]           addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [10:0]           V_ACT    = 11'(V_ACTIVE);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [3:0]            LANE_END = 4'(PIX_PER_WORD - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [31:0]             shreg_q, shreg_d;
  logic [3:0]              lane_q, lane_d;
  logic                    ctrl_en_q, ctrl_en_d;
  logic [4:0]              ctrl_val_q, ctrl_val_d;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Pointer, remaining count, unpacker and latched control config.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      rem_q      <= '0;
      shreg_q    <= '0;
      lane_q     <= '0;
      ctrl_en_q  <= 1'b0;
      ctrl_val_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      shreg_q    <= shreg_d;
      lane_q     <= lane_d;
      ctrl_en_q  <= ctrl_en_d;
      ctrl_val_q <= ctrl_val_d;
    end
  end

  // Next-state and datapath updates; all slot outputs decode from registers
  // only, so s_valid never reaches cs combinationally.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    shreg_d    = shreg_q;
    lane_d     = lane_q;
    ctrl_en_d  = ctrl_en_q;
    ctrl_val_d = ctrl_val_q;
    s_ready    = 1'b0;
    cs         = 1'b0;
    write      = 1'b0;
    addr       = '0;
    wr_data    = '0;
    busy       = (state_q != IDLE) && (state_q != DONE);
    done       = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d      = base_addr;
          rem_d      = pix_count;
          ctrl_en_d  = ctrl_en;
          ctrl_val_d = ctrl_val;
          if (pix_count == '0) state_d = ctrl_en ? CTRL : DONE;
          else if (vsync_wait) state_d = WAIT_VB;
          else                 state_d = FETCH;
        end
      end
      WAIT_VB: begin
        if (y >= V_ACT) state_d = FETCH;
      end
      FETCH: begin
        s_ready = 1'b1;
        if (s_valid) begin
          shreg_d = s_data;
          lane_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        cs      = 1'b1;
        write   = 1'b1;
        addr    = {{(14 - ADDR_WIDTH){1'b0}}, ptr_q};
        wr_data = {{(32 - PIX_BITS){1'b0}}, shreg_q[PIX_BITS-1:0]};
        shreg_d = shreg_q >> PIX_BITS;
        ptr_d   = ptr_q + PTR_ONE;
        rem_d   = rem_q - REM_ONE;
        lane_d  = lane_q + 4'd1;
        // Leftover pixels of a partial final word are simply dropped.
        if (rem_q == REM_ONE)       state_d = ctrl_en_q ? CTRL : DONE;
        else if (lane_q == LANE_END) state_d = FETCH;
      end
      CTRL: begin
        cs      = 1'b1;
        write   = 1'b1;
        addr    = CTRL_REG_ADDR;
        wr_data = {27'b0, ctrl_val_q};
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_sprite_loader.sv
// Directed bench for the sprite RAM loader: drives one load per scenario,
// records slot writes cycle by cycle and compares against hand-derived values.
module tb_vga_sprite_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] pix_count = '0;
  logic        vsync_wait = 1'b0;
  logic        ctrl_en = 1'b0;
  logic [4:0]  ctrl_val = '0;
  logic [10:0] y = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, cs, write, busy, done;
  logic [13:0] addr;
  logic [31:0] wr_data;

  vga_sprite_loader #(.ADDR_WIDTH(10), .V_ACTIVE(480)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .pix_count(pix_count), .vsync_wait(vsync_wait), .ctrl_en(ctrl_en),
    .ctrl_val(ctrl_val), .y(y), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cs(cs), .write(write), .addr(addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] src_q[$];
  logic [13:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int          hs_n, done_n, done_c, rdy_n, rdy_first;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One load: pulse start with the given config, then step cycle by cycle,
  // feeding src_q and logging what the slot port does. Cycle 0 is the cycle
  // right after the start edge.
  task automatic do_load(input logic [9:0] b, input logic [10:0] n,
                         input logic vw, input logic ce, input logic [4:0] cv,
                         input bit tog, input int ystep, input int busy_start,
                         input int abort_pix);
    int c = 0;
    int extra = -1;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    hs_n = 0; done_n = 0; done_c = -1; rdy_n = 0; rdy_first = -1;
    @(posedge clk); #1;
    base_addr = b; pix_count = n; vsync_wait = vw; ctrl_en = ce; ctrl_val = cv;
    start = 1'b1;
    @(negedge clk);
    chk("busy_before_start", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    while (c < 300) begin
      if (c == ystep) y = 11'd480;
      if (c == busy_start) begin
        start = 1'b1; base_addr = 10'd0; pix_count = 11'd1;
      end else if (c == busy_start + 1) start = 1'b0;
      s_valid = (src_q.size() > 0) && (!tog || (c % 2 == 0));
      s_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
      @(negedge clk);
      if (c == 0) chk("busy_cycle_after_start", busy, 1'b1);
      if (cs && write) begin
        wa_q.push_back(addr); wd_q.push_back(wr_data); wc_q.push_back(c);
        if (wa_q.size() == abort_pix + 1) begin
          reset_n = 1'b0;
          #1;
          chk("abort_cs", cs, 1'b0);
          chk("abort_write", write, 1'b0);
          chk("abort_busy", busy, 1'b0);
          chk("abort_addr", addr, 14'h0);
          repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
            chk("abort_no_cs", cs, 1'b0);
          end
          @(posedge clk); #1;
          reset_n = 1'b1;
          s_valid = 1'b0;
          src_q.delete();
          return;
        end
      end
      if (s_valid && s_ready) begin
        hs_n++;
        void'(src_q.pop_front());
      end
      if (s_ready) begin
        if (rdy_first < 0) rdy_first = c;
        rdy_n++;
      end
      if (done) begin
        done_n++;
        done_c = c;
        chk("busy_low_at_done", busy, 1'b0);
        if (extra < 0) extra = 3;
      end
      if (extra == 0) break;
      if (extra > 0) extra--;
      c++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("done_pulse_count", done_n, 1);
  endtask

  initial begin
    int gaps;
    // Reset state.
    #2;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_cs", cs, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_addr", addr, 14'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // One full word, pixels 0,1,2,3 repeating.
    src_q.push_back(32'hE4E4_E4E4);
    do_load(10'd0, 11'd16, 1'b0, 1'b0, 5'd0, 1'b0, -1, -1, -1);
    chk("t1_nwr", wa_q.size(), 16);
    for (int i = 0; i < wa_q.size(); i++) begin
      chk("t1_addr", wa_q[i], 14'(i));
      chk("t1_data", wd_q[i], 32'(i % 4));
    end
    chk("t1_hs", hs_n, 1);
    chk("t1_ready_cycles", rdy_n, 1);
    chk("t1_first_write_cycle", wc_q[0], 1);
    chk("t1_done_cycle", done_c, 17);

    // Address wrap, partial word; upper pixels of the word are discarded.
    src_q.push_back(32'hFFFF_FFB1);
    do_load(10'h3FE, 11'd4, 1'b0, 1'b0, 5'd0, 1'b0, -1, -1, -1);
    chk("t2_nwr", wa_q.size(), 4);
    chk("t2_a0", wa_q[0], 14'h03FE);
    chk("t2_a1", wa_q[1], 14'h03FF);
    chk("t2_a2", wa_q[2], 14'h0000);
    chk("t2_a3", wa_q[3], 14'h0001);
    chk("t2_d0", wd_q[0], 32'd1);
    chk("t2_d1", wd_q[1], 32'd0);
    chk("t2_d2", wd_q[2], 32'd3);
    chk("t2_d3", wd_q[3], 32'd2);
    chk("t2_hs", hs_n, 1);

    // Zero pixels, control write only.
    do_load(10'd7, 11'd0, 1'b0, 1'b1, 5'b00100, 1'b0, -1, -1, -1);
    chk("t3_nwr", wa_q.size(), 1);
    chk("t3_addr", wa_q[0], 14'h2003);
    chk("t3_data", wd_q[0], 32'd4);
    chk("t3_hs", hs_n, 0);
    chk("t3_ready_cycles", rdy_n, 0);
    chk("t3_done_cycle", done_c, wc_q[0] + 1);

    // Wait for blanking: y rises to 480 during cycle 5, FETCH from cycle 6.
    y = 11'd100;
    src_q.push_back(32'h1B1B_1B1B);
    do_load(10'd100, 11'd16, 1'b1, 1'b0, 5'd0, 1'b0, 5, -1, -1);
    y = 11'd0;
    chk("t4_first_ready", rdy_first, 6);
    chk("t4_nwr", wa_q.size(), 16);
    for (int i = 0; i < wa_q.size(); i++) begin
      chk("t4_addr", wa_q[i], 14'(100 + i));
      chk("t4_data", wd_q[i], 32'(3 - (i % 4)));
    end

    // 33 pixels, source valid every other cycle, a start while busy.
    src_q.push_back(32'h5555_5555);
    src_q.push_back(32'hAAAA_AAAA);
    src_q.push_back(32'h0000_0003);
    do_load(10'h200, 11'd33, 1'b0, 1'b0, 5'd0, 1'b1, -1, 10, -1);
    chk("t5_nwr", wa_q.size(), 33);
    chk("t5_hs", hs_n, 3);
    gaps = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      chk("t5_addr", wa_q[i], 14'(32'h200 + i));
      chk("t5_data", wd_q[i], (i < 16) ? 32'd1 : (i < 32) ? 32'd2 : 32'd3);
      if (i > 0 && (i % 16) != 0 && wc_q[i] != wc_q[i-1] + 1) gaps++;
    end
    chk("t5_intra_word_gaps", gaps, 0);
    chk("t5_done_cycle", done_c, 38);

    // Reset while writing pixel 5, then a normal load afterwards.
    src_q.push_back(32'hE4E4_E4E4);
    do_load(10'd0, 11'd16, 1'b0, 1'b0, 5'd0, 1'b0, -1, -1, 5);
    chk("t6_writes_before_abort", wa_q.size(), 6);
    src_q.push_back(32'hE4E4_E4E4);
    do_load(10'd40, 11'd16, 1'b0, 1'b1, 5'd9, 1'b0, -1, -1, -1);
    chk("t6_nwr", wa_q.size(), 17);
    for (int i = 0; i < 16; i++) begin
      chk("t6_addr", wa_q[i], 14'(40 + i));
      chk("t6_data", wd_q[i], 32'(i % 4));
    end
    chk("t6_ctrl_addr", wa_q[16], 14'h2003);
    chk("t6_ctrl_data", wd_q[16], 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
